// File: rtl/lpif_dstrm_rx_buffer.sv
// Receive-side flit buffer for the LPIF dstrm path: captures active-state
// data flits into a small FIFO, tracks link state, reports overflow.

package lpif_dstrm_rx_buffer_pkg;
    // One buffered flit, 531 bits
    typedef struct packed {
        logic         crc_valid;
        logic [15:0]  crc;
        logic [1:0]   protid;
        logic [511:0] data;
    } rx_entry_t;
endpackage

module lpif_dstrm_rx_buffer #(
    parameter int unsigned DEPTH        = 4,
    parameter logic [3:0]  ACTIVE_STATE = 4'h1
) (
    input  logic                     clk_wr,
    input  logic                     rst_wr_n,
    input  logic                     rx_online,
    input  logic [3:0]               dstrm_state,
    input  logic [1:0]               dstrm_protid,
    input  logic [511:0]             dstrm_data,
    input  logic                     dstrm_dvalid,
    input  logic [15:0]              dstrm_crc,
    input  logic                     dstrm_crc_valid,
    input  logic                     dstrm_valid,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_protid,
    output logic [511:0]             out_data,
    output logic [15:0]              out_crc,
    output logic                     out_crc_valid,
    output logic [3:0]               state_q,
    output logic                     state_chg,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow,
    output logic [15:0]              drop_count,
    input  logic                     clr_status
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    lpif_dstrm_rx_buffer_pkg::rx_entry_t mem [DEPTH];
    lpif_dstrm_rx_buffer_pkg::rx_entry_t wr_entry;
    lpif_dstrm_rx_buffer_pkg::rx_entry_t head;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push_req;
    logic          do_push;
    logic          do_pop;
    logic          drop;

    // Occupancy flags and handshake qualification
    always_comb begin
        empty    = (wr_ptr == rd_ptr);
        full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        push_req = rx_online && dstrm_valid && dstrm_dvalid && (dstrm_state == ACTIVE_STATE);
        do_pop   = !empty && out_ready;
        // A full FIFO still takes the flit when the head leaves in the same cycle
        do_push  = push_req && (!full || do_pop);
        drop     = push_req && full && !do_pop;
    end

    // Pack the incoming flit into an entry
    always_comb begin
        wr_entry.crc_valid = dstrm_crc_valid;
        wr_entry.crc       = dstrm_crc;
        wr_entry.protid    = dstrm_protid;
        wr_entry.data      = dstrm_data;
    end

    // Storage; reset to zero so the head fields read 0 out of reset
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_entry;
        end
    end

    // Read/write pointers; going offline empties the FIFO ahead of any push/pop
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (!rx_online) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Head entry presentation straight from storage registers
    always_comb begin
        head          = mem[rd_ptr[AW-1:0]];
        out_valid     = !empty;
        out_protid    = head.protid;
        out_data      = head.data;
        out_crc       = head.crc;
        out_crc_valid = head.crc_valid;
        fill_level    = wr_ptr - rd_ptr;
    end

    // Sticky overflow and saturating drop counter; a same-cycle drop beats clear
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            overflow   <= 1'b0;
            drop_count <= 16'h0000;
        end else if (clr_status) begin
            overflow   <= drop;
            drop_count <= drop ? 16'h0001 : 16'h0000;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'h0001;
            end
        end
    end

    // Link state capture on every valid transfer, independent of rx_online
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            state_q   <= 4'h0;
            state_chg <= 1'b0;
        end else if (dstrm_valid) begin
            state_q   <= dstrm_state;
            state_chg <= (dstrm_state != state_q);
        end else begin
            state_chg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lpif_dstrm_rx_buffer.sv
// Self-checking bench for lpif_dstrm_rx_buffer: vector table, directed
// corner sequences and random traffic against a queue-based reference.

module tb_lpif_dstrm_rx_buffer;

    localparam int unsigned DEPTH = 4;
    localparam logic [3:0]  ACT   = 4'h1;

    logic         clk_wr = 1'b0;
    logic         rst_wr_n;
    logic         rx_online;
    logic [3:0]   dstrm_state;
    logic [1:0]   dstrm_protid;
    logic [511:0] dstrm_data;
    logic         dstrm_dvalid;
    logic [15:0]  dstrm_crc;
    logic         dstrm_crc_valid;
    logic         dstrm_valid;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_protid;
    logic [511:0] out_data;
    logic [15:0]  out_crc;
    logic         out_crc_valid;
    logic [3:0]   state_q;
    logic         state_chg;
    logic [2:0]   fill_level;
    logic         overflow;
    logic [15:0]  drop_count;
    logic         clr_status;

    lpif_dstrm_rx_buffer #(.DEPTH(DEPTH), .ACTIVE_STATE(ACT)) dut (
        .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .rx_online(rx_online),
        .dstrm_state(dstrm_state), .dstrm_protid(dstrm_protid), .dstrm_data(dstrm_data),
        .dstrm_dvalid(dstrm_dvalid), .dstrm_crc(dstrm_crc), .dstrm_crc_valid(dstrm_crc_valid),
        .dstrm_valid(dstrm_valid), .out_valid(out_valid), .out_ready(out_ready),
        .out_protid(out_protid), .out_data(out_data), .out_crc(out_crc),
        .out_crc_valid(out_crc_valid), .state_q(state_q), .state_chg(state_chg),
        .fill_level(fill_level), .overflow(overflow), .drop_count(drop_count),
        .clr_status(clr_status)
    );

    always #5 clk_wr = ~clk_wr;

    // Reference model: a plain queue of flits plus status scalars
    typedef struct {
        logic         cv;
        logic [15:0]  crc;
        logic [1:0]   pid;
        logic [511:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [3:0]  m_sq;
    logic        m_sc;
    logic        m_of;
    logic [15:0] m_dc;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit         on, v, dv;
        logic [3:0] st;
        bit         rdy, clr;
        bit         e_ov;
        int         e_fl;
        logic [3:0] e_sq;
        bit         e_sc;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] pat(input logic [31:0] seed);
        return {16{seed}};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_sq = 4'h0;
        m_sc = 1'b0;
        m_of = 1'b0;
        m_dc = 16'h0000;
    endtask

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_step();
        bit   pop, preq, drop;
        ent_t e;
        pop  = (mq.size() > 0) && out_ready;
        preq = rx_online && dstrm_valid && dstrm_dvalid && (dstrm_state == ACT);
        drop = 1'b0;
        if (!rx_online) begin
            mq.delete();
        end else begin
            if (pop) mq.delete(0);
            if (preq) begin
                if (mq.size() < int'(DEPTH)) begin
                    e.cv   = dstrm_crc_valid;
                    e.crc  = dstrm_crc;
                    e.pid  = dstrm_protid;
                    e.data = dstrm_data;
                    mq.push_back(e);
                end else begin
                    drop = 1'b1;
                end
            end
        end
        if (clr_status) begin
            m_of = drop;
            m_dc = drop ? 16'd1 : 16'd0;
        end else if (drop) begin
            m_of = 1'b1;
            if (m_dc != 16'hFFFF) m_dc = m_dc + 16'd1;
        end
        m_sc = dstrm_valid && (dstrm_state != m_sq);
        if (dstrm_valid) m_sq = dstrm_state;
    endtask

    task automatic check_model();
        chk("m_out_valid", out_valid, mq.size() > 0);
        chk("m_fill_level", fill_level, mq.size());
        chk("m_state_q", state_q, m_sq);
        chk("m_state_chg", state_chg, m_sc);
        chk("m_overflow", overflow, m_of);
        chk("m_drop_count", drop_count, m_dc);
        if (mq.size() > 0) begin
            chk("m_out_data", out_data, mq[0].data);
            chk("m_out_protid", out_protid, mq[0].pid);
            chk("m_out_crc", out_crc, mq[0].crc);
            chk("m_out_crc_valid", out_crc_valid, mq[0].cv);
        end
    endtask

    task automatic drv(input bit on, v, dv, input logic [3:0] st, input bit rdy, clr,
                       input logic [31:0] seed);
        rx_online       = on;
        dstrm_valid     = v;
        dstrm_dvalid    = dv;
        dstrm_state     = st;
        out_ready       = rdy;
        clr_status      = clr;
        dstrm_data      = pat(seed);
        dstrm_protid    = seed[1:0];
        dstrm_crc       = seed[15:0] ^ 16'h5A5A;
        dstrm_crc_valid = seed[0];
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk_wr);
        #1;
        check_model();
    endtask

    task automatic push(input logic [31:0] seed, input bit rdy);
        drv(1, 1, 1, ACT, rdy, 0, seed);
        cycle();
    endtask

    task automatic idle(input bit rdy);
        drv(1, 0, 0, ACT, rdy, 0, 32'h0);
        cycle();
    endtask

    task automatic do_reset();
        rst_wr_n = 1'b0;
        #1;
        model_reset();
        rst_wr_n = 1'b1;
    endtask

    initial begin
        // Table: pure-spec expectations starting from reset, ACTIVE_STATE = 1
        //          on v dv st   rdy clr  ov fl sq   sc
        tbl[0]  = '{1, 1, 1, 4'h1, 0, 0,  1, 1, 4'h1, 1};
        tbl[1]  = '{1, 1, 0, 4'h1, 0, 0,  1, 1, 4'h1, 0};
        tbl[2]  = '{1, 1, 1, 4'h2, 0, 0,  1, 1, 4'h2, 1};
        tbl[3]  = '{1, 0, 1, 4'h2, 0, 0,  1, 1, 4'h2, 0};
        tbl[4]  = '{1, 1, 1, 4'h1, 0, 0,  1, 2, 4'h1, 1};
        tbl[5]  = '{1, 1, 1, 4'h1, 1, 0,  1, 2, 4'h1, 0};
        tbl[6]  = '{1, 0, 0, 4'h1, 1, 0,  1, 1, 4'h1, 0};
        tbl[7]  = '{1, 0, 0, 4'h1, 1, 0,  0, 0, 4'h1, 0};
        tbl[8]  = '{1, 0, 0, 4'h1, 1, 0,  0, 0, 4'h1, 0};
        tbl[9]  = '{0, 1, 1, 4'h1, 0, 0,  0, 0, 4'h1, 0};
        tbl[10] = '{0, 1, 0, 4'h3, 0, 0,  0, 0, 4'h3, 1};
        tbl[11] = '{1, 1, 1, 4'h1, 0, 0,  1, 1, 4'h1, 1};

        rst_wr_n = 1'b0;
        drv(0, 0, 0, 4'h0, 0, 0, 32'h0);
        model_reset();
        #22;
        rst_wr_n = 1'b1;
        #1;
        // Reset values
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_fill_level", fill_level, 3'd0);
        chk("rst_state_q", state_q, 4'h0);
        chk("rst_state_chg", state_chg, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_drop_count", drop_count, 16'h0);
        chk("rst_out_data", out_data, 512'h0);

        for (int i = 0; i < 12; i++) begin
            drv(tbl[i].on, tbl[i].v, tbl[i].dv, tbl[i].st, tbl[i].rdy, tbl[i].clr, 32'(i + 100));
            cycle();
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
            chk($sformatf("tbl%0d_fill_level", i), fill_level, 3'(tbl[i].e_fl));
            chk($sformatf("tbl%0d_state_q", i), state_q, tbl[i].e_sq);
            chk($sformatf("tbl%0d_state_chg", i), state_chg, tbl[i].e_sc);
        end

        // Single flit with fixed fields, then drain
        do_reset();
        drv(1, 1, 1, ACT, 0, 0, 32'h0);
        dstrm_data      = {64{8'hA5}};
        dstrm_protid    = 2'd2;
        dstrm_crc       = 16'h1234;
        dstrm_crc_valid = 1'b1;
        cycle();
        chk("single_valid", out_valid, 1'b1);
        chk("single_data", out_data, {64{8'hA5}});
        chk("single_protid", out_protid, 2'd2);
        chk("single_crc", out_crc, 16'h1234);
        chk("single_fill", fill_level, 3'd1);
        idle(1);
        chk("single_drain_valid", out_valid, 1'b0);
        chk("single_drain_fill", fill_level, 3'd0);

        // Overflow: six pushes into a four-deep FIFO, first four retained in order
        for (int k = 1; k <= 6; k++) push(32'(k), 0);
        chk("ovf_fill", fill_level, 3'd4);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_count", drop_count, 16'd2);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("ovf_order%0d", k), out_data, pat(32'(k)));
            idle(1);
        end
        chk("ovf_empty", out_valid, 1'b0);

        // Full with simultaneous push and pop: no drop, new flit drains last
        for (int k = 10; k <= 13; k++) push(32'(k), 0);
        push(32'd14, 1);
        chk("fullpp_fill", fill_level, 3'd4);
        chk("fullpp_count", drop_count, 16'd2);
        for (int k = 11; k <= 14; k++) begin
            chk($sformatf("fullpp_order%0d", k), out_data, pat(32'(k)));
            idle(1);
        end

        // Flush by rx_online, then clear coinciding with a drop
        for (int k = 20; k <= 22; k++) push(32'(k), 0);
        drv(0, 0, 0, ACT, 0, 0, 32'h0);
        cycle();
        chk("flush_fill", fill_level, 3'd0);
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_keep_count", drop_count, 16'd2);
        for (int k = 30; k <= 33; k++) push(32'(k), 0);
        drv(1, 1, 1, ACT, 0, 1, 32'd34);
        cycle();
        chk("clrdrop_count", drop_count, 16'd1);
        chk("clrdrop_flag", overflow, 1'b1);
        drv(1, 0, 0, ACT, 0, 1, 32'h0);
        cycle();
        chk("clr_count", drop_count, 16'd0);
        chk("clr_flag", overflow, 1'b0);

        // Asynchronous reset between edges with a drop recorded
        drv(1, 1, 1, ACT, 0, 0, 32'd35);
        cycle();
        chk("prerst_count", drop_count, 16'd1);
        #3;
        rst_wr_n = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_fill", fill_level, 3'd0);
        chk("arst_state_q", state_q, 4'h0);
        chk("arst_state_chg", state_chg, 1'b0);
        chk("arst_overflow", overflow, 1'b0);
        chk("arst_count", drop_count, 16'h0);
        chk("arst_data", out_data, 512'h0);
        #2;
        rst_wr_n = 1'b1;
        push(32'd40, 0);
        chk("arst_push_fill", fill_level, 3'd1);
        chk("arst_push_data", out_data, pat(32'd40));

        // Random traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            drv($urandom_range(0, 19) != 0,
                ($urandom % 8) != 0,
                ($urandom % 4) != 0,
                (($urandom % 6) == 0) ? 4'($urandom) : ACT,
                ($urandom % 2) != 0,
                ($urandom % 32) == 0,
                $urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
